// File: rtl/fuzz_stim_sequencer_pkg.sv
// Shared definitions for the fuzz stimulus sequencer.
//   LCG_MUL / LCG_INC : constants of the team's 32-bit LCG (rng*MUL + INC mod 2^32)
//   seq_state_e       : sequencer FSM states
//   nw()              : number of 32-bit LCG words needed to cover an input vector
package fuzz_pkg;
  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [2:0] {IDLE, DUT_RST, FILL, PRESENT, DONE} seq_state_e;

  function automatic int nw(input int in_w);
    return (in_w + 31) / 32;
  endfunction
endpackage

// File: rtl/fuzz_stim_sequencer_if.sv
// DUT-side handshake of the fuzz stimulus sequencer.
//   dut_rst_n : reset driven into the DUT, active-low
//   dut_in    : current DUT input vector
//   vec_valid : dut_in holds a vector not yet accepted
//   vec_ready : consumer accepts the presented vector
// master = sequencer, slave = consumer/DUT wrapper.
interface fuzz_stim_sequencer_if #(parameter int IN_W = 281) ();
  logic            dut_rst_n;
  logic [IN_W-1:0] dut_in;
  logic            vec_valid;
  logic            vec_ready;

  modport master (output dut_rst_n, dut_in, vec_valid, input  vec_ready);
  modport slave  (input  dut_rst_n, dut_in, vec_valid, output vec_ready);
endinterface

// File: rtl/fuzz_stim_sequencer_lcg.sv
// fuzz_lcg32: 32-bit LCG state register.
//   load/seed : overwrite state with seed (wins over step)
//   step      : advance state by one LCG step
//   state_o   : current state
//   next_o    : state after one step (combinational)
module fuzz_lcg32
  import fuzz_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'd2245334677
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state_o,
  output logic [31:0] next_o
);
  logic [31:0] rng_q, rng_d;

  assign next_o  = rng_q * LCG_MUL + LCG_INC;
  assign state_o = rng_q;

  always_comb begin
    rng_d = rng_q;
    if (load)      rng_d = seed;
    else if (step) rng_d = next_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rng_q <= RESET_SEED;
    else        rng_q <= rng_d;
  end
endmodule

// File: rtl/fuzz_stim_sequencer.sv
// fuzz_stim_sequencer: resets one DUT, then presents LCG-generated input
// vectors with a valid/ready handshake and counts accepted vectors.
//   clk, rst_n : clock, async active-low reset
//   seed_load  : capture seed_i (IDLE/DONE only)
//   seed_i     : LCG seed
//   cycles_i   : vectors to present, sampled on start
//   start      : begin a run (IDLE/DONE only)
//   dut_if     : dut_rst_n / dut_in / vec_valid out, vec_ready in
//   cyc_count  : vectors accepted this run (saturating)
//   busy, done : run in progress / run finished
module fuzz_stim_sequencer
  import fuzz_pkg::*;
#(
  parameter int          IN_W         = 281,
  parameter int          WORD_W       = 32,
  parameter int          RST_CYCLES   = 2,
  parameter logic [31:0] DEFAULT_SEED = 32'd2245334677
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seed_load,
  input  logic [31:0]            seed_i,
  input  logic [31:0]            cycles_i,
  input  logic                   start,
  fuzz_stim_sequencer_if.master  dut_if,
  output logic [31:0]            cyc_count,
  output logic                   busy,
  output logic                   done
);
  localparam int NW     = nw(IN_W);
  localparam int LAST_W = IN_W - WORD_W * (NW - 1);
  localparam int WIDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [31:0]       cyc_count_q, cyc_count_d;
  logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [IN_W-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              vec_valid_q, vec_valid_d;
  logic              dut_rst_n_q, dut_rst_n_d;

  logic              lcg_load, lcg_step;
  logic [31:0]       rng_cur, rng_next;
  logic [IN_W-1:0]   fill_vec;

  fuzz_lcg32 #(.RESET_SEED(DEFAULT_SEED)) u_lcg (
    .clk(clk), .rst_n(rst_n), .load(lcg_load), .seed(seed_i),
    .step(lcg_step), .state_o(rng_cur), .next_o(rng_next)
  );

  // Shadow with the word produced this clock merged in; the last word keeps
  // only the LSBs of the LCG value so generation matches the software LCG.
  always_comb begin
    fill_vec = shadow_q;
    for (int k = 0; k < NW - 1; k++)
      if (widx_q == WIDX_W'(k)) fill_vec[k*WORD_W +: WORD_W] = rng_next;
    if (widx_q == WIDX_W'(NW - 1)) fill_vec[IN_W-1 -: LAST_W] = rng_next[LAST_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cyc_count_d = cyc_count_q;
    rst_cnt_d   = rst_cnt_q;
    widx_d      = widx_q;
    shadow_d    = shadow_q;
    dut_in_d    = dut_in_q;
    vec_valid_d = vec_valid_q;
    dut_rst_n_d = dut_rst_n_q;
    lcg_load    = 1'b0;
    lcg_step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        lcg_load = seed_load;  // load lands on the same edge as start
        if (start) begin
          remaining_d = cycles_i;
          cyc_count_d = '0;
          rst_cnt_d   = '0;
          dut_rst_n_d = 1'b0;
          state_d     = DUT_RST;
        end
      end
      DUT_RST: begin
        if (rst_cnt_q == RCNT_W'(RST_CYCLES - 1)) begin
          dut_rst_n_d = 1'b1;
          widx_d      = '0;
          state_d     = (remaining_q != '0) ? FILL : DONE;
        end else begin
          rst_cnt_d = rst_cnt_q + RCNT_W'(1);
        end
      end
      FILL: begin
        lcg_step = 1'b1;
        shadow_d = fill_vec;
        if (widx_q == WIDX_W'(NW - 1)) begin
          dut_in_d    = fill_vec;
          vec_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end
      PRESENT: begin
        if (dut_if.vec_ready) begin
          vec_valid_d = 1'b0;
          if (cyc_count_q != '1) cyc_count_d = cyc_count_q + 32'd1;
          remaining_d = remaining_q - 32'd1;
          widx_d      = '0;
          state_d     = (remaining_q == 32'd1) ? DONE : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cyc_count_q <= '0;
      rst_cnt_q   <= '0;
      widx_q      <= '0;
      shadow_q    <= '0;
      dut_in_q    <= '0;
      vec_valid_q <= 1'b0;
      dut_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cyc_count_q <= cyc_count_d;
      rst_cnt_q   <= rst_cnt_d;
      widx_q      <= widx_d;
      shadow_q    <= shadow_d;
      dut_in_q    <= dut_in_d;
      vec_valid_q <= vec_valid_d;
      dut_rst_n_q <= dut_rst_n_d;
    end
  end

  assign dut_if.dut_rst_n = dut_rst_n_q;
  assign dut_if.dut_in    = dut_in_q;
  assign dut_if.vec_valid = vec_valid_q;
  assign cyc_count        = cyc_count_q;
  assign busy             = (state_q == DUT_RST) || (state_q == FILL) || (state_q == PRESENT);
  assign done             = (state_q == DONE);

  logic unused_ok;
  assign unused_ok = ^rng_cur;
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Testbench for fuzz_stim_sequencer: randomized runs checked against a
// software LCG vector generator.
module tb_fuzz_stim_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0, start = 1'b0;
  logic [31:0] seed_i = '0, cycles_i = '0;
  logic [31:0] cyc_count;
  logic        busy, done;

  fuzz_stim_sequencer_if #(.IN_W(281)) dif ();

  fuzz_stim_sequencer dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_i(seed_i),
    .cycles_i(cycles_i), .start(start), .dut_if(dif),
    .cyc_count(cyc_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0, n_err = 0;
  int           stable_err;
  logic [31:0]  m_rng;
  logic [280:0] obs_q[$];

  // Software LCG: nine steps, each step's value is the next 32-bit word.
  function automatic logic [280:0] model_vec();
    logic [287:0] full;
    full = '0;
    for (int k = 0; k < 9; k++) begin
      m_rng = m_rng * 32'h41C64E6D + 32'h3039;
      full[k*32 +: 32] = m_rng;
    end
    return full[280:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; seed_load = 1'b0; start = 1'b0; dif.vec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic kick(input bit ld, input logic [31:0] s, input logic [31:0] n);
    seed_load = ld; seed_i = s; cycles_i = n; start = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0; start = 1'b0;
  endtask

  // Drives vec_ready (and optional stray start/seed_load while busy) until
  // done, recording every accepted vector and any change of a held vector.
  task automatic collect(input int ready_pct, input bit disturb);
    bit           holding = 1'b0;
    logic [280:0] held = '0;
    obs_q.delete();
    stable_err = 0;
    for (int i = 0; i < 3000 && done !== 1'b1; i++) begin
      if (dif.vec_valid === 1'b1) begin
        if (holding && dif.dut_in !== held) stable_err++;
        if (int'($urandom_range(99)) < ready_pct) begin
          obs_q.push_back(dif.dut_in); dif.vec_ready = 1'b1; holding = 1'b0;
        end else begin
          dif.vec_ready = 1'b0; holding = 1'b1; held = dif.dut_in;
        end
      end else begin
        dif.vec_ready = $urandom_range(1) == 1;
      end
      if (disturb && busy === 1'b1) begin
        start = $urandom_range(3) == 0; seed_load = $urandom_range(3) == 0;
        seed_i = $urandom; cycles_i = $urandom;
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      @(posedge clk); #1;
    end
    dif.vec_ready = 1'b0; start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (dif.dut_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_dut_rst_n: got %b exp 0", dif.dut_rst_n); end
    n_cmp++; if (dif.dut_in !== '0) begin n_err++; $display("FAIL reset_dut_in: got %h exp 0", dif.dut_in); end
    n_cmp++; if ({dif.vec_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b exp 000", {dif.vec_valid, busy, done}); end
    n_cmp++; if (cyc_count !== 32'd0) begin n_err++; $display("FAIL reset_cyc_count: got %0d exp 0", cyc_count); end
  endtask

  task automatic test_seed0();
    int           rst_low = 0, fill = 0;
    logic [280:0] exp_v;
    do_reset();
    m_rng = 32'd0; exp_v = model_vec();
    seed_load = 1'b1; seed_i = 32'd0;
    @(posedge clk); #1 seed_load = 1'b0;
    kick(1'b0, 32'd0, 32'd1);
    while (dif.dut_rst_n === 1'b0 && rst_low < 50) begin rst_low++; @(posedge clk); #1; end
    n_cmp++; if (rst_low !== 2) begin n_err++; $display("FAIL seed0_rst_len: got %0d exp 2", rst_low); end
    while (dif.vec_valid !== 1'b1 && fill < 50) begin fill++; @(posedge clk); #1; end
    n_cmp++; if (fill !== 9) begin n_err++; $display("FAIL seed0_fill_latency: got %0d exp 9", fill); end
    n_cmp++; if (dif.dut_in[31:0] !== 32'h00003039) begin n_err++; $display("FAIL seed0_word0: got %h exp 00003039", dif.dut_in[31:0]); end
    n_cmp++; if (dif.dut_in[63:32] !== 32'hD3DC167E) begin n_err++; $display("FAIL seed0_word1: got %h exp d3dc167e", dif.dut_in[63:32]); end
    n_cmp++; if (dif.dut_in !== exp_v) begin n_err++; $display("FAIL seed0_vec: got %h exp %h", dif.dut_in, exp_v); end
    dif.vec_ready = 1'b1;
    @(posedge clk); #1 dif.vec_ready = 1'b0;
    n_cmp++; if (cyc_count !== 32'd1) begin n_err++; $display("FAIL seed0_cyc_count: got %0d exp 1", cyc_count); end
    n_cmp++; if ({done, busy, dif.vec_valid, dif.dut_rst_n} !== 4'b1001) begin n_err++; $display("FAIL seed0_done: got %b exp 1001", {done, busy, dif.vec_valid, dif.dut_rst_n}); end
  endtask

  task automatic test_abort();
    int           w = 0;
    logic [280:0] exp_v;
    kick(1'b1, 32'd0, 32'd1);
    while (dif.dut_rst_n !== 1'b1 && w < 50) begin w++; @(posedge clk); #1; end
    repeat (4) @(posedge clk);   // words 0..3 written, word 4 in flight
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({dif.dut_rst_n, dif.vec_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL abort_flags: got %b exp 0000", {dif.dut_rst_n, dif.vec_valid, busy, done}); end
    n_cmp++; if (dif.dut_in !== '0) begin n_err++; $display("FAIL abort_dut_in: got %h exp 0", dif.dut_in); end
    n_cmp++; if (cyc_count !== 32'd0) begin n_err++; $display("FAIL abort_cyc_count: got %0d exp 0", cyc_count); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_rng = 32'd0; exp_v = model_vec();
    kick(1'b1, 32'd0, 32'd1);
    collect(100, 1'b0);
    n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL abort_rerun_count: got %0d exp 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== exp_v) begin n_err++; $display("FAIL abort_rerun_vec: got %h exp %h", obs_q[0], exp_v); end
    end
    n_cmp++; if ({done, cyc_count} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL abort_rerun_done: got %b/%0d exp 1/1", done, cyc_count); end
  endtask

  task automatic test_default_seed();
    logic [280:0] exp_v;
    do_reset();
    m_rng = 32'd2245334677;
    kick(1'b0, 32'd0, 32'd3);
    collect(100, 1'b0);
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL dflt_count: got %0d exp 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      exp_v = model_vec();
      n_cmp++; if (obs_q[i] !== exp_v) begin n_err++; $display("FAIL dflt_vec%0d: got %h exp %h", i, obs_q[i], exp_v); end
      n_cmp++; if (obs_q[i][280:256] !== m_rng[24:0]) begin n_err++; $display("FAIL dflt_top%0d: got %h exp %h", i, obs_q[i][280:256], m_rng[24:0]); end
    end
    n_cmp++; if ({done, cyc_count} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL dflt_done: got %b/%0d exp 1/3", done, cyc_count); end
  endtask

  // Restart from DONE without a seed: the LCG sequence continues.
  task automatic test_back_to_back();
    logic [280:0] exp_v;
    kick(1'b0, 32'd0, 32'd2);
    collect(50, 1'b0);
    n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d exp 2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      exp_v = model_vec();
      n_cmp++; if (obs_q[i] !== exp_v) begin n_err++; $display("FAIL b2b_vec%0d: got %h exp %h", i, obs_q[i], exp_v); end
    end
    n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL b2b_stable: got %0d changes exp 0", stable_err); end
    n_cmp++; if (cyc_count !== 32'd2) begin n_err++; $display("FAIL b2b_cyc_count: got %0d exp 2", cyc_count); end
  endtask

  task automatic test_backpressure();
    int           w = 0;
    logic [31:0]  s, c;
    logic [280:0] v, exp_v;
    s = $urandom; m_rng = s;
    kick(1'b1, s, 32'd2);
    while (dif.vec_valid !== 1'b1 && w < 50) begin w++; @(posedge clk); #1; end
    exp_v = model_vec(); v = dif.dut_in; c = cyc_count;
    n_cmp++; if (v !== exp_v) begin n_err++; $display("FAIL bp_vec0: got %h exp %h", v, exp_v); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({dif.vec_valid, dif.dut_in, cyc_count} !== {1'b1, v, 32'd0}) begin n_err++; $display("FAIL bp_hold%0d: got %b/%h/%0d exp 1/%h/0", i, dif.vec_valid, dif.dut_in, cyc_count, v); end
    end
    dif.vec_ready = 1'b1;
    @(posedge clk); #1 dif.vec_ready = 1'b0;
    n_cmp++; if ({dif.vec_valid, cyc_count} !== {1'b0, c + 32'd1}) begin n_err++; $display("FAIL bp_accept: got %b/%0d exp 0/%0d", dif.vec_valid, cyc_count, c + 32'd1); end
    collect(100, 1'b0);
    exp_v = model_vec();
    n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== exp_v) begin n_err++; $display("FAIL bp_vec1: got %0d vecs exp 1 of %h", obs_q.size(), exp_v); end
    n_cmp++; if ({done, cyc_count} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL bp_done: got %b/%0d exp 1/2", done, cyc_count); end
  endtask

  task automatic test_zero_cycles();
    int nb = 0;
    bit vv = 1'b0;
    kick(1'b0, 32'd0, 32'd0);
    while (busy === 1'b1 && nb < 50) begin
      nb++; if (dif.vec_valid !== 1'b0) vv = 1'b1;
      dif.vec_ready = 1'b1;
      @(posedge clk); #1;
    end
    dif.vec_ready = 1'b0;
    n_cmp++; if (nb !== 2) begin n_err++; $display("FAIL zero_busy_len: got %0d exp 2", nb); end
    n_cmp++; if ({vv, dif.vec_valid} !== 2'b00) begin n_err++; $display("FAIL zero_no_valid: got %b exp 00", {vv, dif.vec_valid}); end
    n_cmp++; if ({done, cyc_count} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL zero_done: got %b/%0d exp 1/0", done, cyc_count); end
  endtask

  task automatic test_ignored();
    logic [31:0]  s;
    logic [280:0] exp_v;
    s = $urandom; m_rng = s;
    kick(1'b1, s, 32'd4);
    collect(60, 1'b1);
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL ign_count: got %0d exp 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      exp_v = model_vec();
      n_cmp++; if (obs_q[i] !== exp_v) begin n_err++; $display("FAIL ign_vec%0d: got %h exp %h", i, obs_q[i], exp_v); end
    end
    n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL ign_stable: got %0d changes exp 0", stable_err); end
    n_cmp++; if ({done, cyc_count} !== {1'b1, 32'd4}) begin n_err++; $display("FAIL ign_done: got %b/%0d exp 1/4", done, cyc_count); end
  endtask

  initial begin
    dif.vec_ready = 1'b0;
    #2;
    test_reset();
    test_seed0();
    test_abort();
    test_default_seed();
    test_back_to_back();
    test_backpressure();
    test_zero_cycles();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
